board_arbiter: RTL and testbench
================================

# board_arbiter

Owns the playfield cell memory of BLOCKS_VERTICAL × BLOCKS_HORIZONTAL 3-bit block types, and shares its single access port between two users. The video renderer has absolute priority and one-cycle read latency. Game logic uses a req/ack read/write port, and a built-in clear sequencer zeroes the board. It sits between the renderer's cell selectors and block-type input and the game-state logic.

## Interface
- BLOCKS_VERTICAL, 12, board rows
- BLOCKS_HORIZONTAL, 21, board columns
- TYPE_W, 3, bits per cell (block type; 0 = empty)

- clk_25_175  in  1  pixel clock, the only clock
- reset  in  1  synchronous, active-high
- vid_active  in  1  renderer reads a cell this cycle (pixel in game area)
- vid_v  in  5  renderer cell row
- vid_h  in  5  renderer cell column
- vid_type  out  TYPE_W  registered cell type for the renderer
- gl_req  in  1  game-logic request; held with fields stable until gl_ack
- gl_we  in  1  1 = write, 0 = read
- gl_v  in  5  request row
- gl_h  in  5  request column
- gl_wdata  in  TYPE_W  write data
- gl_ack  out  1  one-cycle completion pulse
- gl_rdata  out  TYPE_W  cell contents before the access, valid while gl_ack=1
- clr_start  in  1  request a whole-board clear
- clr_busy  out  1  clear in progress

## Operation
- Storage: N = BLOCKS_VERTICAL*BLOCKS_HORIZONTAL entries (252 with defaults), addressed as index = v*BLOCKS_HORIZONTAL + h, 8-bit address.
- The block performs at most one memory access per cycle. Priority order: video, then clear, then game logic.
- FSM states:
  - CLEAR: counter 0..N-1. Writes 0 to cell [counter] and increments in every cycle with vid_active=0. When the write of N-1 is done, the FSM goes to IDLE.
  - IDLE: a clr_start=1 moves the FSM to CLEAR with counter=0. Otherwise a game-logic grant happens when gl_req=1, vid_active=0 and gl_ack=0 in that cycle.
  - If clr_start and a grantable gl_req occur in the same IDLE cycle, the clear wins. The request waits and is served after the clear.
- Video read:
  - With vid_active=1, vid_type is loaded the next cycle with cell (vid_v,vid_h).
  - With vid_active=0, vid_type is loaded with 0.
  - During a clear, video reads return the current contents, which may be partly cleared.
- Game-logic grant:
  - The grant cycle reads the old cell contents. If gl_we=1, it also writes gl_wdata.
  - The next cycle drives gl_ack=1 and gl_rdata=old value.
  - No grant is issued in a cycle where gl_ack=1. This gives the requester one cycle to drop or change gl_req, so a held request is never served twice.
  - Requests are not granted while the FSM is in CLEAR.
- Out of range (v ≥ BLOCKS_VERTICAL or h ≥ BLOCKS_HORIZONTAL):
  - Video reads return 0.
  - Game-logic writes are discarded. Reads return 0. Both are still acked normally.
- clr_start is ignored while clr_busy=1.
- Memory contents are not touched by reset itself. Reset forces a clear.

## Timing
- Reset values: vid_type=0, gl_ack=0, gl_rdata=0, clr_busy=1, state=CLEAR, counter=0.
- The first clear write occurs in the first cycle after reset is released (if vid_active=0).
- Reset mid-transaction: a pending or granted game-logic access gets no gl_ack. Any clear restarts from counter 0.
- Video latency is exactly 1 cycle with no stalls, regardless of any other activity.
- Game-logic latency is grant cycle + 1. The minimum is req to ack = 1 cycle when vid_active=0. It is unbounded while vid_active=1 or clr_busy=1.
- Back-to-back requests: throughput is at most one access every 2 cycles.
- A clear with vid_active held low takes exactly N cycles. clr_busy falls in the cycle after the write of cell N-1, together with the entry to IDLE.
- A clear during active video advances only in cycles with vid_active=0.
- clr_busy, gl_ack, gl_rdata and vid_type are all registered outputs.

## Test plan
- Reset clear:
  - Stimulus: hold reset for 2 cycles, then release with vid_active=0.
  - Required: clr_busy=1 for exactly 252 cycles, then 0. A video read of (11,20) afterwards returns 0.
- Write/read round trip:
  - Stimulus: after the clear, request write (3,5)=5 with vid_active=0.
  - Required: gl_ack one cycle after the grant, gl_rdata=0.
  - Follow-up: a read request of (3,5) gives gl_rdata=5. Video read of (3,5) gives vid_type=5 one cycle later.
- Video priority:
  - Stimulus: gl_req held high with vid_active=1 for 40 cycles, then vid_active=0.
  - Required: no ack during the 40 cycles. Ack arrives 1 cycle after vid_active falls. vid_type is correct every cycle throughout.
- Held request:
  - Stimulus: gl_req kept high across the ack for a write of (0,0)=7.
  - Required: the second grant occurs only after the ack cycle, and its gl_rdata=7. This proves the original write happened exactly once before the re-serve.
- Out of range:
  - Stimulus: write (12,0)=3 and read (0,21).
  - Required: both acked with gl_rdata=0. A full board scan shows no cell changed.
- Clear interaction:
  - Stimulus: clr_start together with gl_req in the same IDLE cycle; also reset asserted mid-clear at counter=100.
  - Required: the clear runs first and the request is acked after clr_busy falls. After the mid-clear reset, the clear restarts and takes 252 cycles.

Source files
------------

// File: rtl/board_arbiter.sv
// Playfield cell memory with a single access port shared by the renderer, the clear sequencer
// and game logic. Priority is video, then clear, then game logic.
module board_arbiter #(
  parameter int BLOCKS_VERTICAL   = 12,
  parameter int BLOCKS_HORIZONTAL = 21,
  parameter int TYPE_W            = 3
) (
  input  logic              clk_25_175,
  input  logic              reset,
  input  logic              vid_active,
  input  logic [4:0]        vid_v,
  input  logic [4:0]        vid_h,
  output logic [TYPE_W-1:0] vid_type,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic [4:0]        gl_v,
  input  logic [4:0]        gl_h,
  input  logic [TYPE_W-1:0] gl_wdata,
  output logic              gl_ack,
  output logic [TYPE_W-1:0] gl_rdata,
  input  logic              clr_start,
  output logic              clr_busy
);
  localparam int N  = BLOCKS_VERTICAL * BLOCKS_HORIZONTAL;
  localparam int AW = 8;
  localparam logic [4:0]    ROWS = 5'(BLOCKS_VERTICAL);
  localparam logic [4:0]    COLS = 5'(BLOCKS_HORIZONTAL);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic              we;
    logic [AW-1:0]     addr;
    logic [TYPE_W-1:0] wdata;
  } acc_t;

  state_t            state, state_next;
  logic [AW-1:0]     cnt, cnt_next;
  logic              grant;
  acc_t              acc;
  logic [TYPE_W-1:0] rd;
  logic [TYPE_W-1:0] mem [N];

  // Address arithmetic may wrap for out-of-range coordinates; every use is gated by the *_ok flag.
  logic          vid_ok, gl_ok;
  logic [AW-1:0] vid_addr, gl_addr;
  assign vid_ok   = (vid_v < ROWS) && (vid_h < COLS);
  assign gl_ok    = (gl_v < ROWS) && (gl_h < COLS);
  assign vid_addr = AW'(vid_v) * AW'(BLOCKS_HORIZONTAL) + AW'(vid_h);
  assign gl_addr  = AW'(gl_v) * AW'(BLOCKS_HORIZONTAL) + AW'(gl_h);

  assign clr_busy = (state == CLEAR);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant      = 1'b0;
    acc        = '{we: 1'b0, addr: vid_addr, wdata: '0};
    case (state)
      CLEAR: begin
        if (!vid_active) begin
          acc = '{we: 1'b1, addr: cnt, wdata: '0};
          if (cnt == LAST) state_next = IDLE;
          else             cnt_next   = cnt + AW'(1);
        end
      end
      IDLE: begin
        if (clr_start) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end else if (gl_req && !vid_active && !gl_ack) begin
          // Skipping grants while gl_ack is high keeps a held request from being served twice.
          grant = 1'b1;
          acc   = '{we: gl_we && gl_ok, addr: gl_addr, wdata: gl_wdata};
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign rd = mem[acc.addr];

  always_ff @(posedge clk_25_175) begin
    if (acc.we && !reset) mem[acc.addr] <= acc.wdata;
  end

  always_ff @(posedge clk_25_175) begin
    if (reset) begin
      state    <= CLEAR;
      cnt      <= '0;
      vid_type <= '0;
      gl_ack   <= 1'b0;
      gl_rdata <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      vid_type <= (vid_active && vid_ok) ? rd : '0;
      gl_ack   <= grant;
      if (grant) gl_rdata <= gl_ok ? rd : '0;
    end
  end
endmodule

// File: tb/tb_board_arbiter.sv
// Directed bench for board_arbiter: clear timing, game-logic access, video priority, range guards.
module tb_board_arbiter;
  logic       clk_25_175 = 1'b0;
  logic       reset, vid_active, gl_req, gl_we, clr_start;
  logic [4:0] vid_v, vid_h, gl_v, gl_h;
  logic [2:0] vid_type, gl_wdata, gl_rdata;
  logic       gl_ack, clr_busy;
  logic [2:0] exp_mem [12][21];
  int checks = 0, errors = 0;

  board_arbiter dut (
    .clk_25_175(clk_25_175), .reset(reset),
    .vid_active(vid_active), .vid_v(vid_v), .vid_h(vid_h), .vid_type(vid_type),
    .gl_req(gl_req), .gl_we(gl_we), .gl_v(gl_v), .gl_h(gl_h), .gl_wdata(gl_wdata),
    .gl_ack(gl_ack), .gl_rdata(gl_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy)
  );

  always #5 clk_25_175 = ~clk_25_175;

  task automatic tick;
    @(posedge clk_25_175);
    #1;
  endtask

  // Drives one request until acked (bounded), then drops it across the ack cycle.
  task automatic gl_do(input logic we, input logic [4:0] v, input logic [4:0] h,
                       input logic [2:0] wd, output logic [2:0] rd, output int cyc);
    gl_req = 1'b1; gl_we = we; gl_v = v; gl_h = h; gl_wdata = wd; cyc = 0;
    do begin tick(); cyc++; end while (!gl_ack && cyc < 600);
    rd = gl_rdata;
    gl_req = 1'b0;
    tick();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (clr_busy && n < 2000) begin
      vid_active = 1'b0;
      tick(); n++;
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1; vid_active = 1'b0; vid_v = '0; vid_h = '0;
    gl_req = 1'b0; gl_we = 1'b0; gl_v = '0; gl_h = '0; gl_wdata = '0; clr_start = 1'b0;
    tick(); tick();
    checks++; if (vid_type !== 3'd0) begin errors++; $display("FAIL reset_vid_type: got %0d expected 0", vid_type); end
    checks++; if (gl_ack !== 1'b0) begin errors++; $display("FAIL reset_gl_ack: got %0b expected 0", gl_ack); end
    checks++; if (gl_rdata !== 3'd0) begin errors++; $display("FAIL reset_gl_rdata: got %0d expected 0", gl_rdata); end
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL reset_clr_busy: got %0b expected 1", clr_busy); end
    reset = 1'b0;
    count_busy(n);
    checks++; if (n != 252) begin errors++; $display("FAIL reset_clear_len: got %0d expected 252", n); end
    vid_active = 1'b1; vid_v = 5'd11; vid_h = 5'd20;
    tick();
    checks++; if (vid_type !== 3'd0) begin errors++; $display("FAIL reset_vid_11_20: got %0d expected 0", vid_type); end
    vid_active = 1'b0;
    tick();
    for (int v = 0; v < 12; v++) for (int h = 0; h < 21; h++) exp_mem[v][h] = 3'd0;
  endtask

  task automatic test_roundtrip;
    logic [2:0] rd; int cyc;
    gl_do(1'b1, 5'd3, 5'd5, 3'd5, rd, cyc); exp_mem[3][5] = 3'd5;
    checks++; if (cyc != 1) begin errors++; $display("FAIL rt_write_latency: got %0d expected 1", cyc); end
    checks++; if (rd !== 3'd0) begin errors++; $display("FAIL rt_write_old: got %0d expected 0", rd); end
    gl_do(1'b0, 5'd3, 5'd5, 3'd0, rd, cyc);
    checks++; if (rd !== 3'd5) begin errors++; $display("FAIL rt_read: got %0d expected 5", rd); end
    vid_active = 1'b1; vid_v = 5'd3; vid_h = 5'd5;
    tick();
    checks++; if (vid_type !== 3'd5) begin errors++; $display("FAIL rt_video: got %0d expected 5", vid_type); end
    vid_active = 1'b0;
    tick();
    checks++; if (vid_type !== 3'd0) begin errors++; $display("FAIL rt_video_idle: got %0d expected 0", vid_type); end
  endtask

  task automatic test_video_priority;
    logic [2:0] ev;
    gl_req = 1'b1; gl_we = 1'b0; gl_v = 5'd3; gl_h = 5'd5;
    for (int i = 0; i < 40; i++) begin
      vid_active = 1'b1;
      vid_v = (i % 2 == 0) ? 5'd3 : 5'd11;
      vid_h = (i % 2 == 0) ? 5'd5 : 5'd20;
      ev    = (i % 2 == 0) ? 3'd5 : 3'd0;
      tick();
      checks++; if (gl_ack !== 1'b0) begin errors++; $display("FAIL vp_no_ack[%0d]: got %0b expected 0", i, gl_ack); end
      checks++; if (vid_type !== ev) begin errors++; $display("FAIL vp_vid[%0d]: got %0d expected %0d", i, vid_type, ev); end
    end
    vid_active = 1'b0;
    tick();
    checks++; if (gl_ack !== 1'b1) begin errors++; $display("FAIL vp_ack: got %0b expected 1", gl_ack); end
    checks++; if (gl_rdata !== 3'd5) begin errors++; $display("FAIL vp_rdata: got %0d expected 5", gl_rdata); end
    checks++; if (vid_type !== 3'd0) begin errors++; $display("FAIL vp_vid_off: got %0d expected 0", vid_type); end
    gl_req = 1'b0;
    tick();
  endtask

  task automatic test_held_request;
    gl_req = 1'b1; gl_we = 1'b1; gl_v = 5'd0; gl_h = 5'd0; gl_wdata = 3'd7;
    tick();
    checks++; if (gl_ack !== 1'b1 || gl_rdata !== 3'd0) begin errors++; $display("FAIL held_first: got ack=%0b rdata=%0d expected ack=1 rdata=0", gl_ack, gl_rdata); end
    tick();
    checks++; if (gl_ack !== 1'b0) begin errors++; $display("FAIL held_gap: got ack=%0b expected 0", gl_ack); end
    tick();
    checks++; if (gl_ack !== 1'b1 || gl_rdata !== 3'd7) begin errors++; $display("FAIL held_second: got ack=%0b rdata=%0d expected ack=1 rdata=7", gl_ack, gl_rdata); end
    gl_req = 1'b0; exp_mem[0][0] = 3'd7;
    tick();
  endtask

  task automatic test_out_of_range;
    logic [2:0] rd; int cyc;
    gl_do(1'b1, 5'd1, 5'd0, 3'd6, rd, cyc); exp_mem[1][0] = 3'd6;
    gl_do(1'b1, 5'd12, 5'd0, 3'd3, rd, cyc);
    checks++; if (cyc != 1 || rd !== 3'd0) begin errors++; $display("FAIL oor_write_12_0: got cyc=%0d rdata=%0d expected cyc=1 rdata=0", cyc, rd); end
    gl_do(1'b0, 5'd0, 5'd21, 3'd0, rd, cyc);
    checks++; if (cyc != 1 || rd !== 3'd0) begin errors++; $display("FAIL oor_read_0_21: got cyc=%0d rdata=%0d expected cyc=1 rdata=0", cyc, rd); end
    gl_do(1'b1, 5'd5, 5'd25, 3'd3, rd, cyc);
    checks++; if (cyc != 1 || rd !== 3'd0) begin errors++; $display("FAIL oor_write_5_25: got cyc=%0d rdata=%0d expected cyc=1 rdata=0", cyc, rd); end
    vid_active = 1'b1; vid_v = 5'd0; vid_h = 5'd21;
    tick();
    checks++; if (vid_type !== 3'd0) begin errors++; $display("FAIL oor_video: got %0d expected 0", vid_type); end
    for (int v = 0; v < 12; v++) for (int h = 0; h < 21; h++) begin
      vid_v = 5'(v); vid_h = 5'(h);
      tick();
      checks++;
      if (vid_type !== exp_mem[v][h]) begin errors++; $display("FAIL scan(%0d,%0d): got %0d expected %0d", v, h, vid_type, exp_mem[v][h]); end
    end
    vid_active = 1'b0;
    tick();
  endtask

  task automatic test_clear_interaction;
    int n;
    clr_start = 1'b1; gl_req = 1'b1; gl_we = 1'b0; gl_v = 5'd3; gl_h = 5'd5;
    tick();
    clr_start = 1'b0;
    checks++; if (clr_busy !== 1'b1 || gl_ack !== 1'b0) begin errors++; $display("FAIL ci_start: got busy=%0b ack=%0b expected busy=1 ack=0", clr_busy, gl_ack); end
    n = 0;
    while (clr_busy && n < 2000) begin
      tick(); n++;
      checks++; if (gl_ack !== 1'b0) begin errors++; $display("FAIL ci_ack_in_clear[%0d]: got %0b expected 0", n, gl_ack); end
    end
    checks++; if (n != 252) begin errors++; $display("FAIL ci_clear_len: got %0d expected 252", n); end
    tick();
    checks++; if (gl_ack !== 1'b1 || gl_rdata !== 3'd0) begin errors++; $display("FAIL ci_ack_after: got ack=%0b rdata=%0d expected ack=1 rdata=0", gl_ack, gl_rdata); end
    gl_req = 1'b0;
    tick();
    // Mid-clear reset at counter 100, with clr_start held to show it is ignored while busy.
    clr_start = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) tick();
    clr_start = 1'b0; gl_req = 1'b1;
    reset = 1'b1;
    tick();
    checks++; if (clr_busy !== 1'b1 || gl_ack !== 1'b0) begin errors++; $display("FAIL ci_reset: got busy=%0b ack=%0b expected busy=1 ack=0", clr_busy, gl_ack); end
    gl_req = 1'b0; reset = 1'b0;
    count_busy(n);
    checks++; if (n != 252) begin errors++; $display("FAIL ci_restart_len: got %0d expected 252", n); end
  endtask

  task automatic test_clear_video_stall;
    int n;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0; n = 0;
    while (clr_busy && n < 2000) begin
      vid_active = ((n + 1) % 2 == 1); vid_v = 5'd11; vid_h = 5'd20;
      tick(); n++;
    end
    vid_active = 1'b0;
    checks++; if (n != 504) begin errors++; $display("FAIL stall_clear_len: got %0d expected 504", n); end
    tick();
  endtask

  initial begin
    test_reset();
    test_roundtrip();
    test_video_priority();
    test_held_request();
    test_out_of_range();
    test_clear_interaction();
    test_clear_video_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
